hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline interlock controller for the minicpu. It sits beside the bypass select logic in ID. It detects load-use hazards that forwarding cannot cover and sequences the multi-cycle multiply/divide unit. It also freezes the pipeline on memory wait, and drives the stall/bubble controls for IF, ID and EX. All ports carry label {L}; no stall decision depends on high-labelled data.

## Interface
Parameters:
- MUL_CYCLES, 4, EX-occupancy cycles of a mult/multu (≥2)
- DIV_CYCLES, 32, EX-occupancy cycles of a div/divu (≥2)
- CNT_W, 6, counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_rs, id_rt  in  5 each  source register specifiers of the ID instruction
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- id_md_start  in  1  ID instruction is mult/multu/div/divu
- id_md_div  in  1  qualifies id_md_start: 1 = divide, 0 = multiply
- id_hilo_rd  in  1  ID instruction is mfhi/mflo
- ex_rd  in  5  destination register of the EX instruction
- ex_memread  in  1  EX instruction is a load
- mem_wait  in  1  data/instruction memory not ready this cycle
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- bubble_ex  out  1  load NOP into ID/EX register
- freeze  out  1  hold every pipeline register (IF/ID through MEM/WB)
- md_busy  out  1  MD unit occupied
- md_done  out  1  one-cycle pulse: HI/LO write-back this cycle

## Operation
- Load-use hazard (lu) = ex_memread & ex_rd≠0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- MD hazard (mdh) = md_busy & (id_md_start | id_hilo_rd).
- Priority: freeze > mdh > lu.
  - freeze = mem_wait. When freeze=1, stall_if/stall_id/bubble_ex = 0 and the FSM holds state and counter.
  - Otherwise, if mdh | lu, then stall_if = stall_id = bubble_ex = 1.
- MD sequencer FSM, registered:
  - IDLE: md_busy=0. On id_md_start & ~freeze & ~lu, go to BUSY and load cnt = (id_md_div ? DIV_CYCLES : MUL_CYCLES) - 2.
  - BUSY: md_busy=1. Decrement cnt each non-frozen cycle. When cnt==0, go to DONE.
  - DONE: md_busy=1, md_done=1. Next non-frozen cycle returns to IDLE.
  - id_md_start arriving in DONE is stalled (mdh). It issues the cycle after return to IDLE.
- Total occupancy from issue edge to IDLE = N cycles (N = MUL_CYCLES or DIV_CYCLES), excluding frozen cycles.
- A start suppressed by lu is not accepted; the re-presented instruction issues after the bubble.
- Write to r0 never causes lu (ex_rd==0 excluded).

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0. Hence md_busy=0 and md_done=0. stall_if, stall_id, bubble_ex and freeze follow the combinational equations, so they are 0 when mem_wait=0.
- Reset mid-operation aborts any MD operation; no md_done is produced.
- Stall/bubble/freeze outputs are combinational from inputs and current state, valid in the same cycle. No registered latency.
- lu lasts exactly 1 cycle per load: after the bubble, EX holds a NOP.
- md_done high exactly 1 cycle per accepted start, mem_wait permitting. If frozen while in DONE, md_done stays high until unfrozen.
- Counter never wraps: cnt is loaded only in IDLE and stops at 0.

## Structure
- FSM state encodings and the MD latency defaults go in mips.h beside the bypass select codes.
- One sub-module: md_seq (FSM + down-counter, outputs md_busy/md_done).
- hazard_ctrl holds the hazard comparators and priority logic.

## Test plan
- Load r5 in EX (ex_memread=1, ex_rd=5), ID id_rs=5, id_use_rs=1 -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle. Same case with ex_rd=0 -> no stall. Same case with id_use_rs=0 -> no stall.
- mult issued (MUL_CYCLES=4) -> md_busy high 4 cycles, md_done high on the 4th. mfhi presented the cycle after issue stalls until the cycle after md_done.
- div (DIV_CYCLES=32) followed by back-to-back mult -> mult stalled 32 cycles, accepted on the cycle the FSM is IDLE.
- mem_wait=1 for 3 cycles mid-divide -> freeze=1, bubble_ex=0, md_done delayed by exactly 3 cycles. mem_wait concurrent with lu -> freeze only.
- id_md_start with a coincident lu -> start not accepted (md_busy stays 0). Accepted the next cycle.
- rst_n low asynchronously while in BUSY -> md_busy drops immediately, no md_done. After release, a new mult completes in MUL_CYCLES.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline interlock controller.
package hazard_ctrl_pkg;

   // Multiply/divide sequencer states
   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   localparam int MUL_CYCLES_DEF = 4;
   localparam int DIV_CYCLES_DEF = 32;
   localparam int CNT_W_DEF      = 6;

   // True when the ID instruction really reads src and src equals dst
   function automatic logic reg_match(input logic use_r,
                                      input logic [4:0] src,
                                      input logic [4:0] dst);
      return use_r && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// Multiply/divide occupancy sequencer: FSM plus down-counter.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   MD_IDLE | unit free, a start may be accepted
//   MD_BUSY | unit occupied, counter running down to 0
//   MD_DONE | last occupancy cycle, HI/LO written back
//
// BUSY lasts N-1 cycles (cnt loaded with N-2 and counted to 0) and DONE
// lasts one, so the unit is occupied exactly N unfrozen cycles.
module hazard_ctrl_md_seq
   import hazard_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_start,
   input  logic i_div,
   input  logic i_freeze,
   output logic o_busy,
   output logic o_done
);

   localparam logic [CNT_W-1:0] LD_MUL = CNT_W'(MUL_CYCLES - 2);
   localparam logic [CNT_W-1:0] LD_DIV = CNT_W'(DIV_CYCLES - 2);

   md_state_e        r_state;
   md_state_e        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   // State and counter registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state and counter; a frozen cycle holds everything
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!i_freeze) begin
         case (r_state)
            MD_IDLE: begin
               if (i_start) begin
                  w_state_nxt = MD_BUSY;
                  w_cnt_nxt   = i_div ? LD_DIV : LD_MUL;
               end
            end
            MD_BUSY: begin
               if (r_cnt == '0) w_state_nxt = MD_DONE;
               else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            MD_DONE: w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
         endcase
      end
   end

   assign o_busy = (r_state != MD_IDLE);
   assign o_done = (r_state == MD_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: load-use and MD hazard detection,
// memory-wait freeze and the IF/ID/EX stall/bubble controls.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       id_md_start,
   input  logic       id_md_div,
   input  logic       id_hilo_rd,
   input  logic [4:0] ex_rd,
   input  logic       ex_memread,
   input  logic       mem_wait,
   output logic       stall_if,
   output logic       stall_id,
   output logic       bubble_ex,
   output logic       freeze,
   output logic       md_busy,
   output logic       md_done
);

   logic w_lu;
   logic w_mdh;
   logic w_hold;
   logic w_start_ok;
   logic w_md_busy;
   logic w_md_done;

   // Hazard detection; r0 writes never interlock
   always_comb begin
      w_lu  = ex_memread && (ex_rd != 5'd0) &&
              (reg_match(id_use_rs, id_rs, ex_rd) ||
               reg_match(id_use_rt, id_rt, ex_rd));
      w_mdh = w_md_busy && (id_md_start || id_hilo_rd);
   end

   // Priority: freeze overrides every stall, MD and load-use stall alike.
   // A start is only taken in IDLE, where mdh cannot be set, so lu and
   // freeze are the only things that can hold it back.
   always_comb begin
      w_hold     = !mem_wait && (w_mdh || w_lu);
      w_start_ok = id_md_start && !mem_wait && !w_lu;
   end

   hazard_ctrl_md_seq #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_md_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (w_start_ok),
      .i_div    (id_md_div),
      .i_freeze (mem_wait),
      .o_busy   (w_md_busy),
      .o_done   (w_md_done)
   );

   assign freeze    = mem_wait;
   assign stall_if  = w_hold;
   assign stall_id  = w_hold;
   assign bubble_ex = w_hold;
   assign md_busy   = w_md_busy;
   assign md_done   = w_md_done;

endmodule
